// File: rtl/mem_resp_router_pkg.sv
// Shared types and helpers for the memory response router.
package mem_resp_router_pkg;
`include "mem_resp_router_defs.sv"

    typedef enum logic {
        TAG_FETCH = `SEL_FETCH,
        TAG_LOAD  = `SEL_LOAD
    } tag_e;

    // An output register can take a new response if empty or draining this cycle.
    function automatic logic port_free(input logic vld, input logic rdy);
        return !vld || rdy;
    endfunction
endpackage

// File: rtl/mem_resp_router_defs.sv
// Requester select encodings shared by the request-side mux and the response router.
`ifndef MEM_RESP_ROUTER_DEFS_SV
`define MEM_RESP_ROUTER_DEFS_SV
`define SEL_FETCH 1'b0
`define SEL_LOAD  1'b1
`endif

// File: rtl/mem_resp_router_tag_fifo.sv
// In-order tag FIFO recording the requester of each issued memory request.
module tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/mem_resp_router.sv
// Routes in-order memory read responses back to the fetch or load requester.
module mem_resp_router
    import mem_resp_router_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        req_issue_valid,
    input  logic                        req_issue_sel,
    output logic                        req_issue_ready,
    input  logic                        resp_valid,
    input  logic [DATA_W-1:0]           resp_data,
    output logic                        resp_ready,
    output logic                        out0_valid,
    output logic [DATA_W-1:0]           out0_data,
    input  logic                        out0_ready,
    output logic                        out1_valid,
    output logic [DATA_W-1:0]           out1_data,
    input  logic                        out1_ready,
    output logic [$clog2(DEPTH+1)-1:0]  outstanding,
    output logic                        err_unexpected
);
    logic [0:0] head_raw;
    tag_e       head_tag;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       fill0;
    logic       fill1;

    tag_fifo #(
        .WIDTH (1),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (req_issue_valid),
        .push_data (req_issue_sel),
        .pop       (pop),
        .head      (head_raw),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (outstanding)
    );

    assign head_tag        = tag_e'(head_raw);
    assign req_issue_ready = !fifo_full;

    // With no outstanding tag the response is accepted and dropped.
    always_comb begin
        resp_ready = 1'b1;
        if (!fifo_empty) begin
            if (head_tag == TAG_LOAD) resp_ready = port_free(out1_valid, out1_ready);
            else                      resp_ready = port_free(out0_valid, out0_ready);
        end
    end

    assign pop   = resp_valid && resp_ready && !fifo_empty;
    assign fill0 = pop && (head_tag == TAG_FETCH);
    assign fill1 = pop && (head_tag == TAG_LOAD);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out0_valid     <= 1'b0;
            out0_data      <= '0;
            out1_valid     <= 1'b0;
            out1_data      <= '0;
            err_unexpected <= 1'b0;
        end else begin
            if (fill0) begin
                out0_valid <= 1'b1;
                out0_data  <= resp_data;
            end else if (out0_valid && out0_ready) begin
                out0_valid <= 1'b0;
            end
            if (fill1) begin
                out1_valid <= 1'b1;
                out1_data  <= resp_data;
            end else if (out1_valid && out1_ready) begin
                out1_valid <= 1'b0;
            end
            err_unexpected <= resp_valid && fifo_empty;
        end
    end
endmodule

// File: tb/tb_mem_resp_router.sv
// Scoreboard bench for mem_resp_router: directed scenarios plus randomized traffic.
module tb_mem_resp_router;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH+1);

    logic              clk;
    logic              reset_n;
    logic              req_issue_valid;
    logic              req_issue_sel;
    logic              req_issue_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_ready;
    logic              out0_valid;
    logic [DATA_W-1:0] out0_data;
    logic              out0_ready;
    logic              out1_valid;
    logic [DATA_W-1:0] out1_data;
    logic              out1_ready;
    logic [CW-1:0]     outstanding;
    logic              err_unexpected;

    mem_resp_router #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_issue_valid (req_issue_valid),
        .req_issue_sel   (req_issue_sel),
        .req_issue_ready (req_issue_ready),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .resp_ready      (resp_ready),
        .out0_valid      (out0_valid),
        .out0_data       (out0_data),
        .out0_ready      (out0_ready),
        .out1_valid      (out1_valid),
        .out1_data       (out1_data),
        .out1_ready      (out1_ready),
        .outstanding     (outstanding),
        .err_unexpected  (err_unexpected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: requester order of outstanding requests, and per-port
    // responses that have been delivered but not yet taken by the consumer.
    bit                tagq[$];
    logic [DATA_W-1:0] exp0[$];
    logic [DATA_W-1:0] exp1[$];
    bit                exp_err;
    bit                mon_en;
    int                errors;
    int                checks;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; entered and left just after a rising edge.
    task automatic cycle(input bit rst, input bit iv, input bit isel, input bit rv,
                         input logic [DATA_W-1:0] rd, input bit r0, input bit r1);
        bit h;
        bit exp_rr;
        bit acc;
        bit do_push;
        reset_n         = !rst;
        req_issue_valid = iv;
        req_issue_sel   = isel;
        resp_valid      = rv;
        resp_data       = rd;
        out0_ready      = r0;
        out1_ready      = r1;
        #2;
        h = (tagq.size() != 0) ? tagq[0] : 1'b0;
        if (tagq.size() == 0) exp_rr = 1'b1;
        else if (h)           exp_rr = (exp1.size() == 0) || r1;
        else                  exp_rr = (exp0.size() == 0) || r0;
        chk("resp_ready", resp_ready, exp_rr);
        chk("req_issue_ready", req_issue_ready, tagq.size() < DEPTH);
        chk("outstanding", outstanding, tagq.size());
        acc     = rv && exp_rr && (tagq.size() != 0);
        do_push = iv && (tagq.size() < DEPTH);
        @(posedge clk);
        if (rst) begin
            tagq.delete();
            exp0.delete();
            exp1.delete();
            exp_err = 1'b0;
        end else begin
            exp_err = rv && (tagq.size() == 0);
            if (acc) begin
                void'(tagq.pop_front());
                if (h) exp1.push_back(rd);
                else   exp0.push_back(rd);
            end
            if (do_push) tagq.push_back(isel);
        end
        #1;
    endtask

    // Monitor: compares presented outputs against the scoreboard, away from the edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out0_valid", out0_valid, exp0.size() != 0);
            if (exp0.size() != 0) begin
                chk("out0_data", out0_data, exp0[0]);
                if (out0_ready) void'(exp0.pop_front());
            end
            chk("out1_valid", out1_valid, exp1.size() != 0);
            if (exp1.size() != 0) begin
                chk("out1_data", out1_data, exp1[0]);
                if (out1_ready) void'(exp1.pop_front());
            end
            chk("err_unexpected", err_unexpected, exp_err);
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        mon_en = 1'b0;
        exp_err = 1'b0;
        reset_n = 1'b0;
        req_issue_valid = 1'b0;
        req_issue_sel = 1'b0;
        resp_valid = 1'b0;
        resp_data = '0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset held for two cycles
        cycle(1, 0, 0, 0, 0, 1, 1);
        cycle(1, 0, 0, 0, 0, 1, 1);
        chk("rst_out0_data", out0_data, 0);
        chk("rst_out1_data", out1_data, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_issue_ready", req_issue_ready, 1);

        // Routing by issue order
        cycle(0, 1, 0, 0, 0, 1, 1);
        cycle(0, 1, 1, 0, 0, 1, 1);
        cycle(0, 1, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 32'hA, 1, 1);
        cycle(0, 0, 0, 1, 32'hB, 1, 1);
        cycle(0, 0, 0, 1, 32'hC, 1, 1);
        cycle(0, 0, 0, 0, 0, 1, 1);
        chk("routing_outstanding", outstanding, 0);

        // Backpressure on the load port
        cycle(0, 1, 1, 0, 0, 1, 0);
        cycle(0, 1, 1, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 32'h1234, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 32'h5678, 1, 0);
        chk("held_out1_data", out1_data, 32'h1234);
        cycle(0, 0, 0, 1, 32'h5678, 1, 1);
        cycle(0, 0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0, 1, 1);

        // Full tag FIFO
        for (int i = 0; i < 4; i++) cycle(0, 1, 1'($urandom_range(0, 1)), 0, 0, 1, 1);
        chk("full_outstanding", outstanding, 4);
        chk("full_issue_ready", req_issue_ready, 0);
        cycle(0, 1, 0, 0, 0, 1, 1);
        chk("ignored_issue", outstanding, 4);
        cycle(0, 1, 0, 1, 32'h44, 1, 1);
        chk("full_pop_no_bypass", outstanding, 3);
        cycle(0, 1, 1, 1, 32'h55, 1, 1);
        chk("push_pop_same_cycle", outstanding, 3);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 32'h60 + 32'(i), 1, 1);
        cycle(0, 0, 0, 0, 0, 1, 1);

        // Unexpected response
        cycle(0, 0, 0, 1, 32'hDEAD, 1, 1);
        cycle(0, 0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0, 1, 1);
        chk("unexpected_outstanding", outstanding, 0);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 32'h66, 0, 0);
        chk("pre_reset_out0_valid", out0_valid, 1);
        chk("pre_reset_outstanding", outstanding, 2);
        cycle(1, 0, 0, 0, 0, 0, 0);
        chk("mid_reset_outstanding", outstanding, 0);
        chk("mid_reset_out0_valid", out0_valid, 0);
        cycle(0, 1, 1, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 32'h77, 1, 1);
        cycle(0, 0, 0, 0, 0, 1, 1);

        // Randomized traffic
        for (int i = 0; i < 50; i++)
            cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, tagq.size() != 0, $urandom, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
